// File: rtl/afe_cfg_pkg.sv
// Shared definitions for the AFE7225 configuration sequencer.
//   - SPI frame geometry (24-bit frame = 8-bit address + 16-bit data)
//   - read-frame address mask
//   - sequencer FSM state enum
//   - max3() helper used to size the shared timer
package afe_cfg_pkg;

  localparam int SPI_FRAME_W = 24;
  localparam int SPI_ADDR_W  = 8;
  localparam int SPI_DATA_W  = 16;

  // MSB of the address byte selects a read frame on the AFE 3-wire bus
  localparam logic [SPI_ADDR_W-1:0] SPI_RD_MASK = 8'h80;

  typedef enum logic [2:0] {
    ST_RST_HOLD,
    ST_RST_WAIT,
    ST_LOAD,
    ST_SHIFT,
    ST_GAP,
    ST_DONE
  } cfg_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/afe_spi_shifter.sv
// afe_spi_shifter: sends one 24-bit frame, MSB first, on the AFE 3-wire SPI
// for each load pulse, and captures the last 16 bits returned on spi_sdout.
//
// Ports
//   clk, reset_n   clock, async active-low reset (sen forced high, sclk low)
//   load           start a frame with 'frame' (ignored while a frame is active)
//   frame[23:0]    frame contents, sampled on load
//   rd_data[15:0]  bits sampled on the last 16 sclk rising edges
//   frame_done     1-clk pulse, registered together with sen returning high
//   spi_sclk/sen/sdata  SPI outputs; spi_sdout  SPI input
//
// Config macro: AFE_CFG_READBACK_EN enables spi_sdout capture; without it
// rd_data is 0 and spi_sdout is unused.
//
// Frame timing (D = CLK_DIV): sen falls on the load edge with bit 23 already
// on sdata; sclk rises on the next edge, then runs 24 periods of D high / D
// low. sdata advances one clk after each falling edge so it is only ever
// touched mid-low. sen rises one clk after the 24th falling edge.
module afe_spi_shifter
  import afe_cfg_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [SPI_FRAME_W-1:0] frame,
  output logic [SPI_DATA_W-1:0] rd_data,
  output logic                  frame_done,
  output logic                  spi_sclk,
  output logic                  spi_sen,
  output logic                  spi_sdata,
  input  logic                  spi_sdout
);

  localparam int            PH_W     = $clog2(2 * CLK_DIV);
  localparam logic [PH_W-1:0] PH_FALL  = PH_W'(CLK_DIV);
  localparam logic [PH_W-1:0] PH_SHIFT = PH_W'(CLK_DIV + 1);
  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(2 * CLK_DIV - 1);
  localparam logic [4:0]      BIT_LAST = 5'(SPI_FRAME_W - 1);

  logic                   active_q, active_d;
  logic [PH_W-1:0]        ph_q, ph_d;
  logic [4:0]             bit_q, bit_d;
  logic [SPI_FRAME_W-1:0] sr_q, sr_d;
  logic                   sclk_q, sclk_d;
  logic                   sen_q, sen_d;
  logic                   sdata_q, sdata_d;
  logic                   done_q, done_d;
`ifdef AFE_CFG_READBACK_EN
  logic [SPI_DATA_W-1:0]  rd_sh_q, rd_sh_d;
`endif

  always_comb begin
    active_d = active_q;
    ph_d     = ph_q;
    bit_d    = bit_q;
    sr_d     = sr_q;
    sclk_d   = sclk_q;
    sen_d    = sen_q;
    sdata_d  = sdata_q;
    done_d   = 1'b0;
`ifdef AFE_CFG_READBACK_EN
    rd_sh_d  = rd_sh_q;
`endif
    if (!active_q) begin
      if (load) begin
        active_d = 1'b1;
        sr_d     = frame;
        sdata_d  = frame[SPI_FRAME_W-1];
        sen_d    = 1'b0;
        sclk_d   = 1'b0;
        ph_d     = '0;
        bit_d    = '0;
      end
    end else begin
      ph_d = (ph_q == PH_LAST) ? '0 : ph_q + 1'b1;
      if (ph_q == PH_LAST) bit_d = bit_q + 1'b1;
      if (ph_q == '0) begin
        sclk_d = 1'b1;
`ifdef AFE_CFG_READBACK_EN
        // shift on every rise; after 24 rises only the data bits remain
        rd_sh_d = {rd_sh_q[SPI_DATA_W-2:0], spi_sdout};
`endif
      end
      if (ph_q == PH_FALL) sclk_d = 1'b0;
      if (ph_q == PH_SHIFT) begin
        if (bit_q == BIT_LAST) begin
          active_d = 1'b0;
          sen_d    = 1'b1;
          sdata_d  = 1'b0;
          done_d   = 1'b1;
          ph_d     = '0;
          bit_d    = '0;
        end else begin
          sr_d    = {sr_q[SPI_FRAME_W-2:0], 1'b0};
          sdata_d = sr_q[SPI_FRAME_W-2];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_q <= 1'b0;
      ph_q     <= '0;
      bit_q    <= '0;
      sr_q     <= '0;
      sclk_q   <= 1'b0;
      sen_q    <= 1'b1;
      sdata_q  <= 1'b0;
      done_q   <= 1'b0;
`ifdef AFE_CFG_READBACK_EN
      rd_sh_q  <= '0;
`endif
    end else begin
      active_q <= active_d;
      ph_q     <= ph_d;
      bit_q    <= bit_d;
      sr_q     <= sr_d;
      sclk_q   <= sclk_d;
      sen_q    <= sen_d;
      sdata_q  <= sdata_d;
      done_q   <= done_d;
`ifdef AFE_CFG_READBACK_EN
      rd_sh_q  <= rd_sh_d;
`endif
    end
  end

  assign spi_sclk   = sclk_q;
  assign spi_sen    = sen_q;
  assign spi_sdata  = sdata_q;
  assign frame_done = done_q;

`ifdef AFE_CFG_READBACK_EN
  assign rd_data = rd_sh_q;
`else
  logic unused_sdout;
  assign unused_sdout = spi_sdout;
  assign rd_data      = '0;
`endif

endmodule

// File: rtl/afe_config_sequencer.sv
// afe_config_sequencer: takes the AFE7225 from power-on to configured.
// Pulses device_reset, waits for the device to settle, then writes NUM_REGS
// 24-bit words fetched from an external synchronous ROM over 3-wire SPI.
// Auto-starts on reset release; start reruns the sequence from DONE only.
//
// Ports
//   clk, reset_n        clock, async active-low reset
//   start               rerun pulse (only honoured in DONE)
//   rom_addr[7:0]       table index; rom_data[23:0] valid 1 clk later
//   device_reset        active-high AFE reset
//   spi_sclk/sen/sdata  SPI to device; spi_sdout  SPI from device
//   busy, done, error   status (error sticky until start)
//
// Config macro: AFE_CFG_READBACK_EN adds a read frame after every write
// frame and flags a data mismatch on error. Without it error is 0.
module afe_config_sequencer
  import afe_cfg_pkg::*;
#(
  parameter int RESET_CYCLES = 16,
  parameter int WAIT_CYCLES  = 65535,
  parameter int CLK_DIV      = 4,
  parameter int NUM_REGS     = 8,
  parameter int GAP_CYCLES   = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  output logic [SPI_ADDR_W-1:0]  rom_addr,
  input  logic [SPI_FRAME_W-1:0] rom_data,
  output logic                   device_reset,
  output logic                   spi_sclk,
  output logic                   spi_sen,
  output logic                   spi_sdata,
  input  logic                   spi_sdout,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  // one timer serves every timed state, so size it to the longest wait
  localparam int              CNT_MAX   = max3(RESET_CYCLES, WAIT_CYCLES, GAP_CYCLES);
  localparam int              CNT_W     = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [SPI_ADDR_W-1:0] IDX_LAST = SPI_ADDR_W'(NUM_REGS - 1);

  cfg_state_e              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
  logic [SPI_ADDR_W-1:0]   idx_q, idx_d;
  logic                    load;
  logic                    advance;
  logic [SPI_FRAME_W-1:0]  frame;
  logic                    frame_done;
  logic [SPI_DATA_W-1:0]   rd_data;
`ifdef AFE_CFG_READBACK_EN
  logic                    rdph_q, rdph_d;   // current frame is the read-back
  logic [SPI_FRAME_W-1:0]  word_q, word_d;   // last word written
  logic                    err_q, err_d;
`endif

  assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;

`ifdef AFE_CFG_READBACK_EN
  assign frame = rdph_q ? {(SPI_RD_MASK | word_q[SPI_FRAME_W-1 -: SPI_ADDR_W]),
                           {SPI_DATA_W{1'b0}}}
                        : rom_data;
`else
  assign frame = rom_data;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    load    = 1'b0;
    advance = 1'b0;
`ifdef AFE_CFG_READBACK_EN
    rdph_d  = rdph_q;
    word_d  = word_q;
    err_d   = err_q;
`endif
    case (state_q)
      ST_RST_HOLD: begin
        if (cnt_q == RST_LAST) begin
          state_d = ST_RST_WAIT;
          cnt_d   = '0;
        end else cnt_d = cnt_inc;
      end
      ST_RST_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end else cnt_d = cnt_inc;
      end
      ST_LOAD: begin
        // first clk presents rom_addr, second clk has rom_data to load
        if (cnt_q == '0) cnt_d = cnt_inc;
        else begin
          load    = 1'b1;
          state_d = ST_SHIFT;
          cnt_d   = '0;
`ifdef AFE_CFG_READBACK_EN
          if (!rdph_q) word_d = rom_data;
`endif
        end
      end
      ST_SHIFT: begin
        if (frame_done) begin
          state_d = ST_GAP;
          cnt_d   = '0;
`ifdef AFE_CFG_READBACK_EN
          if (rdph_q && (rd_data != word_q[SPI_DATA_W-1:0])) err_d = 1'b1;
`endif
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
`ifdef AFE_CFG_READBACK_EN
          if (!rdph_q) begin
            rdph_d  = 1'b1;
            state_d = ST_LOAD;
          end else begin
            rdph_d  = 1'b0;
            advance = 1'b1;
          end
`else
          advance = 1'b1;
`endif
        end else cnt_d = cnt_inc;
        if (advance) begin
          if (idx_q == IDX_LAST) state_d = ST_DONE;
          else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_LOAD;
          end
        end
      end
      ST_DONE: begin
        if (start) begin
          state_d = ST_RST_HOLD;
          cnt_d   = '0;
          idx_d   = '0;
`ifdef AFE_CFG_READBACK_EN
          rdph_d  = 1'b0;
          err_d   = 1'b0;
`endif
        end
      end
      default: state_d = ST_RST_HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RST_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
`ifdef AFE_CFG_READBACK_EN
      rdph_q  <= 1'b0;
      word_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
`ifdef AFE_CFG_READBACK_EN
      rdph_q  <= rdph_d;
      word_q  <= word_d;
      err_q   <= err_d;
`endif
    end
  end

  afe_spi_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load),
    .frame      (frame),
    .rd_data    (rd_data),
    .frame_done (frame_done),
    .spi_sclk   (spi_sclk),
    .spi_sen    (spi_sen),
    .spi_sdata  (spi_sdata),
    .spi_sdout  (spi_sdout)
  );

  assign rom_addr     = idx_q;
  assign device_reset = (state_q == ST_RST_HOLD);
  assign busy         = (state_q != ST_DONE);
  assign done         = (state_q == ST_DONE);

`ifdef AFE_CFG_READBACK_EN
  assign error = err_q;
`else
  logic unused_rd_data;
  assign unused_rd_data = ^rd_data;
  assign error          = 1'b0;
`endif

endmodule

// File: tb/tb_afe_config_sequencer.sv
// Bench for afe_config_sequencer: frames seen on the SPI bus are checked
// against a queue of expected frames filled when each sequence is launched;
// a small device model answers read frames when AFE_CFG_READBACK_EN is set.
module tb_afe_config_sequencer;

  localparam int RESET_CYCLES = 16;
  localparam int WAIT_CYCLES  = 20;
  localparam int CLK_DIV      = 4;
  localparam int NUM_REGS     = 3;
  localparam int GAP_CYCLES   = 8;
  localparam int LIM          = 5000;
`ifdef AFE_CFG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  localparam int FPS = RB ? 2 * NUM_REGS : NUM_REGS;
  localparam logic [23:0] ROM [NUM_REGS] = '{24'h0A1234, 24'h05ABCD, 24'h3C00FF};

  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, spi_sdout = 1'b0;
  logic [7:0] rom_addr;
  logic [23:0] rom_data = '0;
  logic device_reset, spi_sclk, spi_sen, spi_sdata, busy, done, error;

  afe_config_sequencer #(
    .RESET_CYCLES(RESET_CYCLES), .WAIT_CYCLES(WAIT_CYCLES), .CLK_DIV(CLK_DIV),
    .NUM_REGS(NUM_REGS), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .rom_addr(rom_addr),
    .rom_data(rom_data), .device_reset(device_reset), .spi_sclk(spi_sclk),
    .spi_sen(spi_sen), .spi_sdata(spi_sdata), .spi_sdout(spi_sdout),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // synchronous config ROM
  always @(posedge clk)
    rom_data <= (int'(rom_addr) < NUM_REGS) ? ROM[rom_addr[1:0]] : 24'h0;

  int checks = 0, failures = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: timeout after %0d cycles", nm, LIM);
  endtask

  // scoreboard
  logic [23:0] exp_q[$];
  int  frames_started = 0, frames_seen = 0, trunc = 0, viol = 0, inv = 0;
  int  bitcnt = 0, last_rise = 0, last_sen_rise = 0, sen_high = 0;
  bit  in_frame = 1'b0, first_frame = 1'b1, is_rd = 1'b0;
  logic [23:0] sh = '0;
  logic [15:0] rdval = '0;
  logic [15:0] regs [128];
  logic prev_sen = 1'b1, prev_sclk = 1'b0, prev_sdata = 1'b0, prev_done = 1'b0, prev_rstn = 1'b0;

  task automatic push_seq();
    for (int i = 0; i < NUM_REGS; i++) begin
      exp_q.push_back(ROM[i]);
      if (RB) exp_q.push_back({8'h80 | ROM[i][23:16], 16'h0});
    end
    frames_started = 0;
    first_frame    = 1'b1;
  endtask

  // bus monitor + device model, sampled mid-cycle
  always @(negedge clk) begin
    if (reset_n && prev_rstn) begin
      if ((spi_sclk || prev_sclk) && (spi_sdata !== prev_sdata)) viol++;
      if (done === busy) inv++;
    end
    if (spi_sen) sen_high++;
    if (prev_sen && !spi_sen) begin
      if (!first_frame) begin
        checks++;
        if (sen_high < GAP_CYCLES) begin
          failures++;
          $display("FAIL sen_gap: got %0d clks expected >= %0d", sen_high, GAP_CYCLES);
        end
      end
      first_frame = 1'b0; in_frame = 1'b1; bitcnt = 0; sh = '0; is_rd = 1'b0;
      frames_started++;
    end
    if (in_frame && !spi_sen && spi_sclk && !prev_sclk) begin
      if (bitcnt > 0) chk("sclk_period", 32'(cyc - last_rise), 32'(2 * CLK_DIV));
      last_rise = cyc;
      sh = {sh[22:0], spi_sdata};
      bitcnt++;
    end
    if (in_frame && !spi_sen && !spi_sclk && prev_sclk) begin
      if (bitcnt == 8) begin
        is_rd = sh[7];
        rdval = regs[sh[6:0]];
        if (rdval == 16'h1234) rdval = 16'h1235;
      end
      if (is_rd && bitcnt >= 8 && bitcnt < 24) spi_sdout = rdval[23 - bitcnt];
    end
    if (!prev_sen && spi_sen) begin
      last_sen_rise = cyc; sen_high = 0; spi_sdout = 1'b0;
      if (in_frame) begin
        if (bitcnt == 24) begin
          frames_seen++;
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL frame: got unexpected 0x%06h expected none", sh);
          end else chk("frame", 32'(sh), 32'(exp_q.pop_front()));
          if (!sh[23]) regs[sh[22:16]] = sh[15:0];
        end else trunc++;
      end
      in_frame = 1'b0;
    end
    if (!prev_done && done) begin
      checks++;
      if ((cyc - last_sen_rise) < GAP_CYCLES || (cyc - last_sen_rise) > GAP_CYCLES + 3) begin
        failures++;
        $display("FAIL done_delay: got %0d clks expected %0d..%0d", cyc - last_sen_rise,
                 GAP_CYCLES, GAP_CYCLES + 3);
      end
    end
    prev_sen = spi_sen; prev_sclk = spi_sclk; prev_sdata = spi_sdata;
    prev_done = done; prev_rstn = reset_n;
  end

  task automatic wait_done(input string nm);
    int n = 0;
    while (!done && n < LIM) begin @(negedge clk); n++; end
    if (n >= LIM) timeout(nm);
  endtask

  task automatic wait_dr_low(input string nm);
    int n = 0;
    while (device_reset && n < LIM) begin @(negedge clk); n++; end
    if (n >= LIM) timeout(nm);
  endtask

  task automatic wait_bit(input int fr, input int b, input string nm);
    int n = 0;
    while (!(frames_started == fr && bitcnt == b && in_frame) && n < LIM) begin
      @(negedge clk); n++;
    end
    if (n >= LIM) timeout(nm);
  endtask

  initial begin
    int c0, c1, n;
    foreach (regs[i]) regs[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_device_reset", 32'(device_reset), 1);
    chk("rst_sclk", 32'(spi_sclk), 0);
    chk("rst_sen", 32'(spi_sen), 1);
    chk("rst_sdata", 32'(spi_sdata), 0);
    chk("rst_rom_addr", 32'(rom_addr), 0);
    chk("rst_busy", 32'(busy), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);

    // sequence 1: auto-start on reset release
    push_seq();
    reset_n = 1'b1;
    c0 = cyc;
    wait_dr_low("wait_rst_hold");
    chk("rst_hold_clks", 32'(cyc - c0), 32'(RESET_CYCLES));
    c1 = cyc;
    n = 0;
    while (spi_sen && n < LIM) begin @(negedge clk); n++; end
    if (n >= LIM) timeout("wait_first_sen");
    chk("first_sen_fall", 32'(cyc - c1), 32'(WAIT_CYCLES + 2));

    // start while busy is ignored
    wait_bit(1, 5, "wait_mid_shift");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_start_dev_reset", 32'(device_reset), 0);
    chk("busy_start_busy", 32'(busy), 1);
    wait_done("wait_done_1");
    chk("done1_busy", 32'(busy), 0);
    chk("done1_error", 32'(error), 32'(RB));
    chk("done1_queue_empty", 32'(exp_q.size()), 0);
    chk("done1_frames", 32'(frames_seen), 32'(FPS));
    repeat (5) @(negedge clk);
    chk("done1_error_sticky", 32'(error), 32'(RB));

    // sequence 2: start in DONE
    push_seq();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_done", 32'(done), 0);
    chk("restart_dev_reset", 32'(device_reset), 1);
    chk("restart_error", 32'(error), 0);
    chk("restart_busy", 32'(busy), 1);
    c0 = cyc;
    wait_dr_low("wait_rst_hold_2");
    chk("rst_hold_clks_2", 32'(cyc - c0), 32'(RESET_CYCLES));
    wait_done("wait_done_2");
    chk("done2_error", 32'(error), 32'(RB));
    chk("done2_frames", 32'(frames_seen), 32'(2 * FPS));

    // sequence 3: aborted by reset at bit 10 of the second frame
    push_seq();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_bit(2, 10, "wait_frame2_bit10");
    reset_n = 1'b0;
    #1;
    chk("abort_sen", 32'(spi_sen), 1);
    chk("abort_sclk", 32'(spi_sclk), 0);
    chk("abort_dev_reset", 32'(device_reset), 1);
    chk("abort_rom_addr", 32'(rom_addr), 0);
    repeat (3) @(negedge clk);
    exp_q.delete();

    // sequence 4: restart from index 0 after release
    push_seq();
    reset_n = 1'b1;
    wait_done("wait_done_4");
    chk("done4_error", 32'(error), 32'(RB));
    chk("done4_queue_empty", 32'(exp_q.size()), 0);
    chk("total_frames", 32'(frames_seen), 32'(3 * FPS + 1));
    chk("truncated_frames", 32'(trunc), 1);
    chk("sdata_while_sclk_high", 32'(viol), 0);
    chk("done_busy_exclusive", 32'(inv), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
